// File: rtl/wb_completion_arbiter.sv
// rtl/wb_completion_arbiter.sv - merges ALU/load results onto two writeback ports with an overflow FIFO
// Optional macro WB_PERF_CNT_EN adds stall-cycle and queued-result counters.
module wb_completion_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex0_valid,
  input  logic [4:0]                 ex0_rd,
  input  logic [XLEN-1:0]            ex0_data,
  input  logic                       ex1_valid,
  input  logic [4:0]                 ex1_rd,
  input  logic [XLEN-1:0]            ex1_data,
  input  logic                       ld_valid,
  input  logic [4:0]                 ld_rd,
  input  logic [XLEN-1:0]            ld_data,
  output logic                       wb0_we,
  output logic [4:0]                 wb0_rd,
  output logic [XLEN-1:0]            wb0_data,
  output logic                       wb1_we,
  output logic [4:0]                 wb1_rd,
  output logic [XLEN-1:0]            wb1_data,
  output logic                       src_stall,
  output logic                       ovf_err,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic [31:0]                perf_stall_cycles,
  output logic [31:0]                perf_queued
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [PW-1:0]   rptr, wptr;

  logic [2:0]      in_v;
  logic [4:0]      in_rd   [3];
  logic [XLEN-1:0] in_data [3];

  logic [1:0]      n_we;
  logic [4:0]      n_rd   [2];
  logic [XLEN-1:0] n_data [2];
  logic [2:0]      push_en;
  logic [PW-1:0]   push_idx [3];
  logic [1:0]      n_pop;
  logic [1:0]      n_push;
  logic            ovf_set;
  logic [CW-1:0]   count_next;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % DEPTH);
  endfunction

  // Incoming sources listed in push priority order: ld, ex0, ex1; rd=0 never writes back.
  assign in_v[0]    = ld_valid  && (ld_rd  != 5'd0);
  assign in_v[1]    = ex0_valid && (ex0_rd != 5'd0);
  assign in_v[2]    = ex1_valid && (ex1_rd != 5'd0);
  assign in_rd[0]   = ld_rd;
  assign in_rd[1]   = ex0_rd;
  assign in_rd[2]   = ex1_rd;
  assign in_data[0] = ld_data;
  assign in_data[1] = ex0_data;
  assign in_data[2] = ex1_data;

  always_comb begin
    int slot;
    int pushes;
    int free_slots;
    n_we       = '0;
    n_rd[0]    = '0;
    n_rd[1]    = '0;
    n_data[0]  = '0;
    n_data[1]  = '0;
    push_en    = '0;
    for (int i = 0; i < 3; i++) push_idx[i] = '0;
    ovf_set    = 1'b0;
    slot       = 0;
    pushes     = 0;
    for (int k = 0; k < 2; k++) begin
      if (int'(q_count) > k) begin
        n_we[slot]  = 1'b1;
        if (slot == 0) begin
          n_rd[0]   = mem_rd[wrap(int'(rptr) + k)];
          n_data[0] = mem_data[wrap(int'(rptr) + k)];
        end else begin
          n_rd[1]   = mem_rd[wrap(int'(rptr) + k)];
          n_data[1] = mem_data[wrap(int'(rptr) + k)];
        end
        slot = slot + 1;
      end
    end
    n_pop      = 2'(slot);
    // Popped entries free their space in the same cycle, so pushes may reuse it.
    free_slots = DEPTH - int'(q_count) + slot;
    for (int i = 0; i < 3; i++) begin
      if (in_v[i]) begin
        if (slot < 2) begin
          if (slot == 0) begin
            n_we[0]   = 1'b1;
            n_rd[0]   = in_rd[i];
            n_data[0] = in_data[i];
          end else begin
            n_we[1]   = 1'b1;
            n_rd[1]   = in_rd[i];
            n_data[1] = in_data[i];
          end
          slot = slot + 1;
        end else if (pushes < free_slots) begin
          push_en[i]  = 1'b1;
          push_idx[i] = wrap(int'(wptr) + pushes);
          pushes      = pushes + 1;
        end else begin
          ovf_set = 1'b1;
        end
      end
    end
    n_push     = 2'(pushes);
    count_next = CW'(int'(q_count) - int'(n_pop) + pushes);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb0_we    <= 1'b0;
      wb0_rd    <= '0;
      wb0_data  <= '0;
      wb1_we    <= 1'b0;
      wb1_rd    <= '0;
      wb1_data  <= '0;
      rptr      <= '0;
      wptr      <= '0;
      q_count   <= '0;
      src_stall <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      wb0_we    <= n_we[0];
      wb0_rd    <= n_rd[0];
      wb0_data  <= n_data[0];
      wb1_we    <= n_we[1];
      wb1_rd    <= n_rd[1];
      wb1_data  <= n_data[1];
      rptr      <= wrap(int'(rptr) + int'(n_pop));
      wptr      <= wrap(int'(wptr) + int'(n_push));
      q_count   <= count_next;
      // Threshold leaves room for three pushes in the cycle after deassertion.
      src_stall <= (int'(count_next) > DEPTH - 3);
      ovf_err   <= ovf_err | ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push_en[i]) begin
        mem_rd[push_idx[i]]   <= in_rd[i];
        mem_data[push_idx[i]] <= in_data[i];
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_queued       <= '0;
    end else begin
      if (src_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      perf_queued <= perf_queued + 32'(n_push);
    end
  end
`else
  assign perf_stall_cycles = '0;
  assign perf_queued       = '0;
`endif

endmodule

// File: tb/tb_wb_completion_arbiter.sv
// tb/tb_wb_completion_arbiter.sv - randomized self-checking bench against a queue-based reference model
// Perf counter expectations follow WB_PERF_CNT_EN.
module tb_wb_completion_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ex0_valid = 1'b0, ex1_valid = 1'b0, ld_valid = 1'b0;
  logic [4:0]      ex0_rd = '0, ex1_rd = '0, ld_rd = '0;
  logic [XLEN-1:0] ex0_data = '0, ex1_data = '0, ld_data = '0;
  logic            wb0_we, wb1_we, src_stall, ovf_err;
  logic [4:0]      wb0_rd, wb1_rd;
  logic [XLEN-1:0] wb0_data, wb1_data;
  logic [$clog2(DEPTH+1)-1:0] q_count;
  logic [31:0]     perf_stall_cycles, perf_queued;

  wb_completion_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex0_valid(ex0_valid), .ex0_rd(ex0_rd), .ex0_data(ex0_data),
    .ex1_valid(ex1_valid), .ex1_rd(ex1_rd), .ex1_data(ex1_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb0_we(wb0_we), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_we(wb1_we), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .src_stall(src_stall), .ovf_err(ovf_err), .q_count(q_count),
    .perf_stall_cycles(perf_stall_cycles), .perf_queued(perf_queued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  logic            e_we0, e_we1, e_stall, e_ovf;
  logic [4:0]      e_rd0, e_rd1;
  logic [XLEN-1:0] e_d0, e_d1;
  logic [31:0]     e_pstall, e_pq;
  int              checks = 0;
  int              failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_we0 = 0; e_we1 = 0; e_rd0 = 0; e_rd1 = 0; e_d0 = 0; e_d1 = 0;
    e_stall = 0; e_ovf = 0; e_pstall = 0; e_pq = 0;
  endtask

  // Candidates: two oldest queued results, then filtered ld/ex0/ex1; first two win, rest queue.
  task automatic model_step();
    ent_t cand[$];
    ent_t inc[$];
    int   npop;
    npop = (mq.size() < 2) ? mq.size() : 2;
    for (int k = 0; k < npop; k++) cand.push_back(mq[k]);
    if (ld_valid  && ld_rd  != 0) inc.push_back('{ld_rd,  ld_data});
    if (ex0_valid && ex0_rd != 0) inc.push_back('{ex0_rd, ex0_data});
    if (ex1_valid && ex1_rd != 0) inc.push_back('{ex1_rd, ex1_data});
    foreach (inc[i]) cand.push_back(inc[i]);
    if (e_stall) e_pstall = e_pstall + 1;
    e_we0 = 0; e_rd0 = 0; e_d0 = 0; e_we1 = 0; e_rd1 = 0; e_d1 = 0;
    if (cand.size() > 0) begin e_we0 = 1; e_rd0 = cand[0].rd; e_d0 = cand[0].data; end
    if (cand.size() > 1) begin e_we1 = 1; e_rd1 = cand[1].rd; e_d1 = cand[1].data; end
    repeat (npop) void'(mq.pop_front());
    for (int i = 2 - npop; i < inc.size(); i++) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(inc[i]);
        e_pq = e_pq + 1;
      end else begin
        e_ovf = 1;
      end
    end
    e_stall = (mq.size() > DEPTH - 3);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wb0_we"},   wb0_we,   e_we0);
    check({tag, ".wb0_rd"},   wb0_rd,   e_rd0);
    check({tag, ".wb0_data"}, wb0_data, e_d0);
    check({tag, ".wb1_we"},   wb1_we,   e_we1);
    check({tag, ".wb1_rd"},   wb1_rd,   e_rd1);
    check({tag, ".wb1_data"}, wb1_data, e_d1);
    check({tag, ".stall"},    src_stall, e_stall);
    check({tag, ".ovf"},      ovf_err,  e_ovf);
    check({tag, ".q_count"},  q_count,  mq.size());
`ifdef WB_PERF_CNT_EN
    check({tag, ".perf_stall"},  perf_stall_cycles, e_pstall);
    check({tag, ".perf_queued"}, perf_queued,       e_pq);
`else
    check({tag, ".perf_stall"},  perf_stall_cycles, 0);
    check({tag, ".perf_queued"}, perf_queued,       0);
`endif
  endtask

  task automatic cycle(input string tag,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                       input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
    ld_valid = lv;  ld_rd = lrd;  ld_data = ldd;
    ex0_valid = v0; ex0_rd = rd0; ex0_data = d0;
    ex1_valid = v1; ex1_rd = rd1; ex1_data = d1;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycle(input string tag, input bit obey);
    logic lv, v0, v1;
    lv = ($urandom_range(0, 9) < 6);
    v0 = ($urandom_range(0, 9) < 6);
    v1 = ($urandom_range(0, 9) < 6);
    if (obey && e_stall) begin lv = 0; v0 = 0; v1 = 0; end
    cycle(tag, lv, 5'($urandom_range(0, 31)), $urandom,
               v0, 5'($urandom_range(0, 31)), $urandom,
               v1, 5'($urandom_range(0, 31)), $urandom);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    cycle("t1", 0, 0, 0, 1, 5, 32'hA, 1, 6, 32'hB);
    check("t1.wb0_rd_const", wb0_rd, 5);
    check("t1.wb1_data_const", wb1_data, 32'hB);

    cycle("t2a", 1, 3, 32'h1, 1, 4, 32'h2, 1, 7, 32'h3);
    check("t2a.q_const", q_count, 1);
    idle("t2b");
    check("t2b.wb0_rd_const", wb0_rd, 7);
    check("t2b.wb1_we_const", wb1_we, 0);

    cycle("t3a", 1, 10, 32'h10, 1, 11, 32'h11, 1, 12, 32'h12);
    cycle("t3b", 1, 13, 32'h13, 1, 14, 32'h14, 1, 15, 32'h15);
    check("t3b.q_const", q_count, 2);
    check("t3b.stall_const", src_stall, 1);
    idle("t3c");
    check("t3c.stall_const", src_stall, 0);
    idle("t3d");

    cycle("t5", 1, 9, 32'h99, 1, 0, 32'h55, 0, 0, 0);
    check("t5.wb0_rd_const", wb0_rd, 9);
    check("t5.q_const", q_count, 0);

    for (int i = 0; i < 6; i++)
      cycle("t4", 1, 5'(16 + i), 32'h100 + i, 1, 5'(22 + i), 32'h200 + i, 1, 5'(1 + i), 32'h300 + i);
    check("t4.ovf_const", ovf_err, 1);
    repeat (4) idle("t4drain");

    // Mid-drain reset: queued results must vanish without writeback.
    cycle("t6a", 1, 2, 32'h21, 1, 3, 32'h22, 1, 4, 32'h23);
    cycle("t6b", 1, 5, 32'h24, 1, 6, 32'h25, 1, 7, 32'h26);
    check("t6b.q_const", q_count, 2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6rst");
    check("t6rst.wb0_we_const", wb0_we, 0);
    ld_valid = 0; ex0_valid = 0; ex1_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) idle("t6post");

    for (int i = 0; i < 300; i++) rand_cycle("rnd_obey", 1);
    for (int i = 0; i < 200; i++) rand_cycle("rnd_ign", 0);
    repeat (4) idle("final_drain");
    check("final.q_const", q_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
